// File: rtl/epl_read_ctrl_if.sv
// Requester and column-mux bus for the EPLFFRAM02 read sequencer.
// Signal names carry the direction as seen from the sequencer.
interface epl_read_ctrl_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
);
  // Requester side
  logic          pReq0_i;
  logic [AW-1:0] pAddr0_i;
  logic          pReq1_i;
  logic [AW-1:0] pAddr1_i;
  logic          pAck0_o;
  logic          pAck1_o;
  logic [DW-1:0] pRdata_o;
  logic          pErr_o;
  logic          pBusy_o;
  // Array / column-mux side
  logic [AW-2:0] pRow_o;
  logic          pWl_o;
  logic [1:0]    pAcy2_o;
  logic          pRead01_o;
  logic          pRead1_i;
  logic [DW-1:0] pDo_i;

  // Sequencer view
  modport slave (
    input  pReq0_i, pAddr0_i, pReq1_i, pAddr1_i, pRead1_i, pDo_i,
    output pAck0_o, pAck1_o, pRdata_o, pErr_o, pBusy_o,
           pRow_o, pWl_o, pAcy2_o, pRead01_o
  );

  // Requester / mux-model view
  modport master (
    output pReq0_i, pAddr0_i, pReq1_i, pAddr1_i, pRead1_i, pDo_i,
    input  pAck0_o, pAck1_o, pRdata_o, pErr_o, pBusy_o,
           pRow_o, pWl_o, pAcy2_o, pRead01_o
  );
endinterface

// File: rtl/epl_read_ctrl.sv
// Round-robin read sequencer in front of the EPLFFRAM02 column read mux.
// Outputs are registered and describe the state being entered, so every
// output lines up with the state it belongs to.
module epl_read_ctrl #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 10,
  parameter int unsigned SENSE_CYC = 2,
  parameter int unsigned TMO_CYC   = 4
) (
  input  logic            pClk_i,
  input  logic            nRst_i,
  epl_read_ctrl_if.slave  bus
);

  localparam int unsigned CW        = 4;
  localparam int unsigned SENSE_EFF = (SENSE_CYC < 1) ? 1 : ((SENSE_CYC > 15) ? 15 : SENSE_CYC);
  localparam int unsigned TMO_EFF   = (TMO_CYC < 1) ? 1 : ((TMO_CYC > 15) ? 15 : TMO_CYC);
  localparam logic [CW-1:0] SENSE_LD = CW'(SENSE_EFF - 1);
  localparam logic [CW-1:0] TMO_LD   = CW'(TMO_EFF);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_SENSE, S_MUX, S_WAIT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  logic          prio_q, prio_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [AW-2:0] row_q, row_d;
  logic          wl_q, wl_d;
  logic [1:0]    acy_q, acy_d;
  logic          rd01_q, rd01_d;
  logic          gnt1;
  logic [AW-1:0] gnt_addr;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    prio_d   = prio_q;
    rdata_d  = rdata_q;
    row_d    = row_q;
    acy_d    = acy_q;
    err_d    = 1'b0;
    rd01_d   = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    // Requester 1 wins when alone, or on a tie when it holds priority
    gnt1     = bus.pReq1_i & (~bus.pReq0_i | prio_q);
    gnt_addr = gnt1 ? bus.pAddr1_i : bus.pAddr0_i;

    case (state_q)
      S_IDLE: begin
        if (bus.pReq0_i || bus.pReq1_i) begin
          id_d    = gnt1;
          row_d   = gnt_addr[AW-1:1];
          acy_d   = gnt_addr[0] ? 2'b10 : 2'b01;
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        cnt_d   = SENSE_LD;
        state_d = S_SENSE;
      end
      S_SENSE: begin
        if (cnt_q == '0) begin
          rd01_d  = 1'b1;
          state_d = S_MUX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_MUX: begin
        cnt_d   = TMO_LD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.pRead1_i) begin
          rdata_d = bus.pDo_i;
          state_d = S_DONE;
        end else if (cnt_q <= CW'(1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        prio_d  = ~id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wl_d   = (state_d == S_ROW) || (state_d == S_SENSE) || (state_d == S_MUX);
    busy_d = (state_d != S_IDLE);
    if (state_d == S_DONE) begin
      ack0_d = ~id_q;
      ack1_d = id_q;
      acy_d  = 2'b00;
    end
  end

  // State and output registers
  always_ff @(posedge pClk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      row_q   <= '0;
      wl_q    <= 1'b0;
      acy_q   <= 2'b00;
      rd01_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      row_q   <= row_d;
      wl_q    <= wl_d;
      acy_q   <= acy_d;
      rd01_q  <= rd01_d;
    end
  end

  assign bus.pAck0_o   = ack0_q;
  assign bus.pAck1_o   = ack1_q;
  assign bus.pRdata_o  = rdata_q;
  assign bus.pErr_o    = err_q;
  assign bus.pBusy_o   = busy_q;
  assign bus.pRow_o    = row_q;
  assign bus.pWl_o     = wl_q;
  assign bus.pAcy2_o   = acy_q;
  assign bus.pRead01_o = rd01_q;

endmodule

// File: tb/tb_epl_read_ctrl.sv
// Directed bench for epl_read_ctrl with a small registered column-mux model.
module tb_epl_read_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic clk;
  logic rst_n;
  epl_read_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  epl_read_ctrl #(.DW(DW), .AW(AW), .SENSE_CYC(2), .TMO_CYC(4)) dut (
    .pClk_i (clk),
    .nRst_i (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int k;
  logic          anyack;
  logic          mux_en;
  logic [DW-1:0] mux_data;
  logic          prev_rd;
  logic [AW-2:0] row_at_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux model: data-valid one cycle after the read strobe, data tagged by row
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd     = 1'b0;
      bus.pRead1_i = 1'b0;
      bus.pDo_i    = 16'hDEAD;
    end else begin
      if (prev_rd && mux_en) begin
        bus.pRead1_i = 1'b1;
        bus.pDo_i    = mux_data ^ DW'(row_at_rd);
      end else begin
        bus.pRead1_i = 1'b0;
        bus.pDo_i    = 16'hDEAD;
      end
      prev_rd = bus.pRead01_o;
      if (bus.pRead01_o) row_at_rd = bus.pRow_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one transaction to its ack and check the whole sequence
  task automatic do_read(input string tag, input int exp_id, input logic [8:0] exp_row,
                         input logic [1:0] exp_acy, input logic [15:0] exp_data,
                         input logic exp_err, input int exp_lat, input int exp_idle,
                         input logic chg_addr);
    int n, b, a, idle, wlpre, rdc;
    logic both, seen_rd, ack0_s, ack1_s, err_s;
    logic [8:0] row_s, row_m;
    logic [1:0] acy_s, acy_m, acy_dn;
    logic [15:0] data_s;
    n = 0; b = -1; a = -1; idle = 0; wlpre = 0; rdc = 0;
    both = 1'b0; seen_rd = 1'b0; ack0_s = 1'b0; ack1_s = 1'b0; err_s = 1'b0;
    row_s = '0; row_m = '0; acy_s = '0; acy_m = '0; acy_dn = 2'b11; data_s = '0;
    while (a < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.pAck0_o && bus.pAck1_o) both = 1'b1;
      if (b < 0) begin
        if (bus.pBusy_o) begin
          b = n; row_s = bus.pRow_o; acy_s = bus.pAcy2_o;
        end else idle++;
      end
      if (b >= 0) begin
        if (chg_addr && n == b + 1) bus.pAddr0_i = 10'h3FF;
        if (bus.pWl_o && !seen_rd && !bus.pRead01_o) wlpre++;
        if (bus.pRead01_o) begin
          rdc++; seen_rd = 1'b1; row_m = bus.pRow_o; acy_m = bus.pAcy2_o;
        end
        if (bus.pAck0_o || bus.pAck1_o) begin
          a = n; ack0_s = bus.pAck0_o; ack1_s = bus.pAck1_o;
          err_s = bus.pErr_o; data_s = bus.pRdata_o; acy_dn = bus.pAcy2_o;
        end
      end
    end
    if (a < 0) begin
      chk($sformatf("%s.ack_seen", tag), 32'd0, 32'd1);
      return;
    end
    chk($sformatf("%s.ack0", tag), 32'(ack0_s), 32'(exp_id == 0));
    chk($sformatf("%s.ack1", tag), 32'(ack1_s), 32'(exp_id == 1));
    chk($sformatf("%s.both_acks", tag), 32'(both), 32'd0);
    chk($sformatf("%s.row", tag), 32'(row_s), 32'(exp_row));
    chk($sformatf("%s.row_at_mux", tag), 32'(row_m), 32'(exp_row));
    chk($sformatf("%s.acy", tag), 32'(acy_s), 32'(exp_acy));
    chk($sformatf("%s.acy_at_mux", tag), 32'(acy_m), 32'(exp_acy));
    chk($sformatf("%s.acy_done", tag), 32'(acy_dn), 32'd0);
    chk($sformatf("%s.wl_before_rd", tag), 32'(wlpre), 32'd3);
    chk($sformatf("%s.rd_pulses", tag), 32'(rdc), 32'd1);
    chk($sformatf("%s.rdata", tag), 32'(data_s), 32'(exp_data));
    chk($sformatf("%s.err", tag), 32'(err_s), 32'(exp_err));
    chk($sformatf("%s.latency", tag), 32'(a - b + 1), 32'(exp_lat));
    if (exp_idle >= 0) chk($sformatf("%s.idle_gap", tag), 32'(idle), 32'(exp_idle));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pReq0_i = 1'b0; bus.pReq1_i = 1'b0;
    bus.pAddr0_i = '0;  bus.pAddr1_i = '0;
    mux_en = 1'b1; mux_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ack0", 32'(bus.pAck0_o), 32'd0);
    chk("rst.ack1", 32'(bus.pAck1_o), 32'd0);
    chk("rst.rdata", 32'(bus.pRdata_o), 32'd0);
    chk("rst.err", 32'(bus.pErr_o), 32'd0);
    chk("rst.busy", 32'(bus.pBusy_o), 32'd0);
    chk("rst.row", 32'(bus.pRow_o), 32'd0);
    chk("rst.wl", 32'(bus.pWl_o), 32'd0);
    chk("rst.acy", 32'(bus.pAcy2_o), 32'd0);
    chk("rst.rd01", 32'(bus.pRead01_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single even-column read from requester 0
    bus.pAddr0_i = 10'h006; mux_data = 16'hA5A6; bus.pReq0_i = 1'b1;
    do_read("single", 0, 9'h003, 2'b01, 16'hA5A5, 1'b0, 6, 0, 1'b0);
    bus.pReq0_i = 1'b0;
    @(negedge clk);
    chk("single.ack_one_cycle", 32'(bus.pAck0_o), 32'd0);
    chk("single.rdata_held", 32'(bus.pRdata_o), 32'h0000A5A5);
    @(negedge clk);

    // Odd column from requester 1
    bus.pAddr1_i = 10'h00B; mux_data = 16'h1234; bus.pReq1_i = 1'b1;
    do_read("odd", 1, 9'h005, 2'b10, 16'h1231, 1'b0, 6, -1, 1'b0);
    bus.pReq1_i = 1'b0;
    repeat (2) @(negedge clk);

    // Round-robin with both requests held
    bus.pAddr0_i = 10'h006; bus.pAddr1_i = 10'h00B; mux_data = 16'h5A00;
    bus.pReq0_i = 1'b1; bus.pReq1_i = 1'b1;
    do_read("rr0", 0, 9'h003, 2'b01, 16'h5A03, 1'b0, 6, -1, 1'b0);
    do_read("rr1", 1, 9'h005, 2'b10, 16'h5A05, 1'b0, 6, 1, 1'b0);
    do_read("rr2", 0, 9'h003, 2'b01, 16'h5A03, 1'b0, 6, 1, 1'b0);
    do_read("rr3", 1, 9'h005, 2'b10, 16'h5A05, 1'b0, 6, 1, 1'b0);
    bus.pReq0_i = 1'b0; bus.pReq1_i = 1'b0;
    repeat (2) @(negedge clk);

    // Mux never answers: four WAIT cycles then error ack with zero data
    mux_en = 1'b0; bus.pReq1_i = 1'b1;
    do_read("tmo", 1, 9'h005, 2'b10, 16'h0000, 1'b1, 9, -1, 1'b0);
    bus.pReq1_i = 1'b0; mux_en = 1'b1;
    @(negedge clk);
    chk("tmo.err_one_cycle", 32'(bus.pErr_o), 32'd0);
    @(negedge clk);

    // Normal read after a timeout
    bus.pAddr0_i = 10'h3FF; mux_data = 16'h0F0F; bus.pReq0_i = 1'b1;
    do_read("recover", 0, 9'h1FF, 2'b10, 16'h0EF0, 1'b0, 6, -1, 1'b0);
    bus.pReq0_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during SENSE while requester 1 holds priority
    bus.pReq1_i = 1'b1;
    k = 0;
    while (!bus.pWl_o && k < 20) begin @(negedge clk); k++; end
    chk("rst_mid.wl_seen", 32'(bus.pWl_o), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.wl", 32'(bus.pWl_o), 32'd0);
    chk("rst_mid.acy", 32'(bus.pAcy2_o), 32'd0);
    chk("rst_mid.busy", 32'(bus.pBusy_o), 32'd0);
    chk("rst_mid.rd01", 32'(bus.pRead01_o), 32'd0);
    bus.pReq1_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    anyack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.pAck0_o || bus.pAck1_o || bus.pBusy_o) anyack = 1'b1;
    end
    chk("rst_mid.no_ack", 32'(anyack), 32'd0);
    bus.pAddr0_i = 10'h006; bus.pAddr1_i = 10'h00B; mux_data = 16'h0000;
    bus.pReq0_i = 1'b1; bus.pReq1_i = 1'b1;
    do_read("rst_prio", 0, 9'h003, 2'b01, 16'h0003, 1'b0, 6, 0, 1'b0);
    bus.pReq0_i = 1'b0; bus.pReq1_i = 1'b0;
    repeat (2) @(negedge clk);

    // Address changes after grant are ignored
    bus.pAddr0_i = 10'h006; mux_data = 16'hBEE0; bus.pReq0_i = 1'b1;
    do_read("addr_chg", 0, 9'h003, 2'b01, 16'hBEE3, 1'b0, 6, -1, 1'b1);
    bus.pReq0_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
